// File: rtl/display_scan_buffer_pkg.sv
// Shared definitions for the display scan buffer: the 5-bit character
// encoding, the blank (NULL) code and the buffer control state type.
package display_pkg;

  localparam logic [4:0] NULL_CODE = 5'h1F;

  // Hex digits map directly onto their value; the remaining codes are glyphs.
  localparam logic [4:0] CH_0    = 5'h00;
  localparam logic [4:0] CH_1    = 5'h01;
  localparam logic [4:0] CH_2    = 5'h02;
  localparam logic [4:0] CH_3    = 5'h03;
  localparam logic [4:0] CH_4    = 5'h04;
  localparam logic [4:0] CH_5    = 5'h05;
  localparam logic [4:0] CH_6    = 5'h06;
  localparam logic [4:0] CH_7    = 5'h07;
  localparam logic [4:0] CH_8    = 5'h08;
  localparam logic [4:0] CH_9    = 5'h09;
  localparam logic [4:0] CH_A    = 5'h0A;
  localparam logic [4:0] CH_B    = 5'h0B;
  localparam logic [4:0] CH_C    = 5'h0C;
  localparam logic [4:0] CH_D    = 5'h0D;
  localparam logic [4:0] CH_E    = 5'h0E;
  localparam logic [4:0] CH_F    = 5'h0F;
  localparam logic [4:0] CH_DASH = 5'h10;
  localparam logic [4:0] CH_H    = 5'h11;
  localparam logic [4:0] CH_L    = 5'h12;
  localparam logic [4:0] CH_P    = 5'h13;
  localparam logic [4:0] CH_U    = 5'h14;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_buffer_scan_tick_gen.sv
// Digit scan timing: a SCAN_DIV-cycle dwell prescaler whose terminal count
// advances the scanned digit index, wrapping after NUM_DIGITS digits.
module scan_tick_gen #(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] scan_idx
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PRE_W-1:0] r_presc;
  logic [IDX_W-1:0] r_scan_idx;
  logic             w_scan_tick;

  assign w_scan_tick = (r_presc == PRE_W'(SCAN_DIV - 1));
  assign scan_idx    = r_scan_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_scan_idx <= '0;
    end else begin
      r_presc <= w_scan_tick ? '0 : r_presc + 1'b1;
      if (w_scan_tick) begin
        r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_scan_buffer.sv
// Character shift buffer for a multiplexed NUM_DIGITS-digit display: pushes
// enter at cell 0, backspace removes the newest, clear blanks cells one per cycle.
module display_scan_buffer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              char_valid,
  input  logic [4:0]                        char_code,
  output logic                              char_ready,
  input  logic                              cmd_backspace,
  input  logic                              cmd_clear,
  output logic [4:0]                        ln_binary,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   char_count
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  scan_state_e      r_state, w_state_next;
  logic [IDX_W-1:0] r_clr_idx, w_clr_idx_next;
  logic [CNT_W-1:0] r_count;
  logic [4:0]       r_cells     [NUM_DIGITS];
  logic [4:0]       w_cell_next [NUM_DIGITS];
  logic [IDX_W-1:0] w_scan_idx;
  logic             w_clear_start;
  logic             w_do_bs;
  logic             w_do_push;

  scan_tick_gen #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .scan_idx (w_scan_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  // Priority clear > backspace > push; commands arriving while clearing are dropped.
  always_comb begin
    w_state_next   = r_state;
    w_clr_idx_next = r_clr_idx;
    w_clear_start  = 1'b0;
    w_do_bs        = 1'b0;
    w_do_push      = 1'b0;
    char_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        char_ready = !cmd_clear && !cmd_backspace;
        if (cmd_clear) begin
          w_clear_start  = 1'b1;
          w_state_next   = ST_CLEARING;
          w_clr_idx_next = '0;
        end else if (cmd_backspace) begin
          w_do_bs = (r_count != '0);
        end else if (char_valid) begin
          w_do_push = 1'b1;
        end
      end
      ST_CLEARING: begin
        if (r_clr_idx == IDX_W'(NUM_DIGITS - 1)) begin
          w_state_next   = ST_IDLE;
          w_clr_idx_next = '0;
        end else begin
          w_clr_idx_next = r_clr_idx + 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_clr_idx_next = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cell
      logic [4:0] w_from_above;
      logic [4:0] w_from_below;
      logic       w_clr_hit;

      if (gi == NUM_DIGITS - 1) begin : g_top
        assign w_from_above = NULL_CODE;
      end else begin : g_mid_above
        assign w_from_above = r_cells[gi+1];
      end

      if (gi == 0) begin : g_bottom
        assign w_from_below = char_code;
      end else begin : g_mid_below
        assign w_from_below = r_cells[gi-1];
      end

      assign w_clr_hit = (r_state == ST_CLEARING) && (r_clr_idx == IDX_W'(gi));

      assign w_cell_next[gi] = w_clr_hit ? NULL_CODE    :
                               w_do_bs   ? w_from_above :
                               w_do_push ? w_from_below :
                                           r_cells[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_cells[i] <= NULL_CODE;
      end
    end else begin
      r_cells <= w_cell_next;
    end
  end

  // The count drops to zero as soon as a clear is taken, ahead of the cell wipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_clear_start) begin
      r_count <= '0;
    end else if (w_do_bs) begin
      r_count <= r_count - 1'b1;
    end else if (w_do_push && (r_count != CNT_W'(NUM_DIGITS))) begin
      r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    an = '1;
    if (r_state != ST_CLEARING) begin
      an[w_scan_idx] = 1'b0;
    end
  end

  assign ln_binary  = r_cells[w_scan_idx];
  assign char_count = r_count;

endmodule

// File: tb/tb_display_scan_buffer.sv
// Directed bench for display_scan_buffer (8 digits, 4-cycle dwell); cell
// contents are observed through the scanned ln_binary/an outputs.
module tb_display_scan_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       char_valid;
  logic [4:0] char_code;
  logic       char_ready;
  logic       cmd_backspace;
  logic       cmd_clear;
  logic [4:0] ln_binary;
  logic [7:0] an;
  logic [3:0] char_count;

  int checks   = 0;
  int failures = 0;

  logic [4:0] cell_obs [8];

  always #5 clk = ~clk;

  display_scan_buffer #(
    .NUM_DIGITS (8),
    .SCAN_DIV   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .char_valid    (char_valid),
    .char_code     (char_code),
    .char_ready    (char_ready),
    .cmd_backspace (cmd_backspace),
    .cmd_clear     (cmd_clear),
    .ln_binary     (ln_binary),
    .an            (an),
    .char_count    (char_count)
  );

  // Watch one full scan rotation and capture each cell as its anode is lit.
  task automatic read_cells();
    for (int i = 0; i < 8; i++) cell_obs[i] = 5'bx;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (an == ~(8'b1 << i)) cell_obs[i] = ln_binary;
      end
    end
  endtask

  task automatic check_cells(input string name, input logic [39:0] exp_flat);
    read_cells();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cell_obs[i] !== exp_flat[i*5 +: 5]) begin
        failures++;
        $display("FAIL %s cell[%0d] got=%h want=%h", name, i, cell_obs[i], exp_flat[i*5 +: 5]);
      end
    end
  endtask

  task automatic check_count(input string name, input logic [3:0] exp);
    checks++;
    if (char_count !== exp) begin
      failures++;
      $display("FAIL %s char_count got=%0d want=%0d", name, char_count, exp);
    end
  endtask

  task automatic push(input logic [4:0] code);
    @(negedge clk);
    char_valid = 1'b1;
    char_code  = code;
    @(negedge clk);
    char_valid = 1'b0;
    $display("push code=%h count=%0d", code, char_count);
  endtask

  task automatic backspace();
    @(negedge clk);
    cmd_backspace = 1'b1;
    @(negedge clk);
    cmd_backspace = 1'b0;
    $display("backspace count=%0d", char_count);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; char_valid = 1'b0; char_code = 5'h00;
    cmd_backspace = 1'b0; cmd_clear = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 8'hFE || ln_binary !== 5'h1F || char_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs an=%h ln=%h rdy=%b want FE/1F/1", an, ln_binary, char_ready);
    end
    check_count("reset", 4'd0);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an == 8'hFE && n < 10);
    checks++;
    if (n !== 4 || an !== 8'hFD) begin
      failures++;
      $display("FAIL reset_first_tick cycles=%0d an=%h want 4/FD", n, an);
    end
    $display("reset done first_tick_cycles=%0d", n);
  endtask

  task automatic test_scan();
    logic [7:0] prev;
    int n;
    for (int k = 0; k < 9; k++) begin
      prev = an;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (an == prev && n < 10);
      checks++;
      if (n !== 4 || an !== {prev[6:0], prev[7]}) begin
        failures++;
        $display("FAIL scan_step%0d cycles=%0d an=%h want 4/%h", k, n, an, {prev[6:0], prev[7]});
      end
      $display("scan step an=%h dwell=%0d", an, n);
    end
  endtask

  task automatic test_push();
    push(5'h01); push(5'h02); push(5'h03);
    check_count("push", 4'd3);
    check_cells("push", {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h02, 5'h03});
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 9; c++) push(5'(c));
    check_count("overflow", 4'd8);
    check_cells("overflow", {5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08});
  endtask

  task automatic test_backspace();
    for (int k = 1; k <= 9; k++) begin
      backspace();
      check_count("backspace", (k >= 8) ? 4'd0 : 4'(8 - k));
      if (k == 3) check_cells("backspace3", {5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05});
      if (k >= 8) check_cells("backspace_empty", {8{5'h1F}});
    end
  endtask

  task automatic test_clear();
    int n;
    push(5'h0A); push(5'h0B); push(5'h0C);
    @(negedge clk);
    cmd_clear = 1'b1; char_valid = 1'b1; char_code = 5'h15;
    #1;
    checks++;
    if (char_ready !== 1'b0) begin
      failures++;
      $display("FAIL clear_ready_cmd got=%b want=0", char_ready);
    end
    @(negedge clk);
    cmd_clear = 1'b0;
    check_count("clear_first", 4'd0);
    n = 0;
    while (an == 8'hFF && char_ready == 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 8 || char_ready !== 1'b1) begin
      failures++;
      $display("FAIL clear_window cycles=%0d rdy=%b want 8/1", n, char_ready);
    end
    $display("clear blank_cycles=%0d", n);
    @(negedge clk);
    char_valid = 1'b0;
    check_count("clear_push", 4'd1);
    check_cells("clear", {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h15});
  endtask

  task automatic test_collision();
    push(5'h04);
    check_count("coll_pre", 4'd2);
    @(negedge clk);
    cmd_backspace = 1'b1; char_valid = 1'b1; char_code = 5'h07;
    #1;
    checks++;
    if (char_ready !== 1'b0) begin
      failures++;
      $display("FAIL coll_ready got=%b want=0", char_ready);
    end
    @(negedge clk);
    cmd_backspace = 1'b0; char_valid = 1'b0;
    check_count("coll_bs", 4'd1);
    check_cells("coll_bs", {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h15});
    $display("collision backspace+push count=%0d", char_count);
    @(negedge clk);
    cmd_clear = 1'b1; cmd_backspace = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0; cmd_backspace = 1'b0;
    checks++;
    if (an !== 8'hFF) begin
      failures++;
      $display("FAIL coll_clear_an got=%h want=FF", an);
    end
    check_count("coll_clear", 4'd0);
    repeat (10) @(negedge clk);
    check_cells("coll_clear", {8{5'h1F}});
    $display("collision clear+backspace count=%0d", char_count);
  endtask

  task automatic test_reset_mid_clear();
    push(5'h02); push(5'h09);
    @(negedge clk);
    cmd_clear = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 8'hFE || ln_binary !== 5'h1F || char_ready !== 1'b1) begin
      failures++;
      $display("FAIL midclear_reset an=%h ln=%h rdy=%b want FE/1F/1", an, ln_binary, char_ready);
    end
    check_count("midclear_reset", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_cells("midclear_reset", {8{5'h1F}});
    $display("reset mid-clear an=%h count=%0d", an, char_count);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_push();
    test_overflow();
    test_backspace();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_buffer.md
DISPLAY_SCAN_BUFFER -- requirements
Module: display_scan_buffer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of character cells and anodes.
REQ-002 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit dwell, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port char_valid, input, 1 bit: char_code is offered this cycle.
REQ-006 SHALL have port char_code, input, 5 bits: character code in the team's 5-bit display encoding.
REQ-007 SHALL have port char_ready, output, 1 bit: block accepts char_code this cycle.
REQ-008 SHALL have port cmd_backspace, input, 1 bit: single-cycle pulse, delete newest character.
REQ-009 SHALL have port cmd_clear, input, 1 bit: single-cycle pulse, blank all cells.
REQ-010 SHALL have port ln_binary, output, 5 bits: code of the currently scanned cell, fed to the segment decoder.
REQ-011 SHALL have port an, output, NUM_DIGITS bits: anode enables, active-low, one-hot-low.
REQ-012 SHALL have port char_count, output, clog2(NUM_DIGITS+1) bits: number of non-blank cells held.

Function
REQ-013 SHALL hold NUM_DIGITS cells, cell 0 = rightmost/newest, each reset to NULL (5'h1F).
REQ-014 SHALL accept a character on any cycle where char_valid and char_ready are both high: cell[i] <= cell[i-1] for i>0, cell[0] <= char_code, visible on ln_binary from the next cycle.
REQ-015 SHALL, on a push while char_count == NUM_DIGITS, discard cell[NUM_DIGITS-1] and hold char_count at NUM_DIGITS.
REQ-016 SHALL, on cmd_backspace with char_count > 0, shift cell[i] <= cell[i+1], cell[NUM_DIGITS-1] <= NULL, char_count decrements by 1.
REQ-017 SHALL treat cmd_backspace with char_count == 0 as a no-op.
REQ-018 SHALL apply priority when events coincide: cmd_clear > cmd_backspace > push; a lower-priority push is not accepted (char_ready low that cycle).
REQ-019 SHALL implement FSM states IDLE and CLEARING; IDLE -> CLEARING on cmd_clear; CLEARING writes NULL to cell k at clear index k = 0..NUM_DIGITS-1, one per cycle, then returns to IDLE; char_count is 0 from the first CLEARING cycle.
REQ-020 SHALL drive char_ready = 1 only in IDLE with cmd_clear and cmd_backspace both low.
REQ-021 SHALL ignore cmd_backspace and cmd_clear received in CLEARING.
REQ-022 SHALL run a prescaler 0..SCAN_DIV-1 that wraps to 0 and pulses scan_tick on its terminal value; each scan_tick advances scan_idx by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-023 SHALL drive an[scan_idx] = 0 and all other bits 1, except in CLEARING, where an = all ones (blanked).
REQ-024 SHALL drive ln_binary = cell[scan_idx] combinationally from registered state.
REQ-025 SHALL keep scanning unaffected by push, backspace or clear.

Reset
REQ-026 SHALL, while rst_n is low, force immediately: all cells NULL, FSM IDLE, prescaler 0, scan_idx 0, char_count 0.
REQ-027 SHALL present outputs in reset: an = ~1 (only bit 0 low), ln_binary = 5'h1F, char_ready = 1 (provided commands are low).
REQ-028 SHALL abort a CLEARING sequence on rst_n assertion mid-clear, leaving the reset state.
REQ-029 SHALL resume after rst_n deasserts with the first scan_tick SCAN_DIV cycles later.

Structure
REQ-030 SHALL use a shared package display_pkg holding NULL_CODE = 5'h1F, the 5-bit character code constants, and the FSM state enum type.
REQ-031 SHALL place the prescaler and scan_idx counter in one sub-module, scan_tick_gen (parameters SCAN_DIV, NUM_DIGITS; outputs scan_idx).
REQ-032 SHALL be implemented in 120-400 lines of RTL with no latches.

Verification
REQ-033 SHALL cover push: with SCAN_DIV=4, push 5'h01, 5'h02, 5'h03 -> cells[2:0] = 01,02,03, char_count = 3, ln_binary = 5'h03 when an = 8'hFE.
REQ-034 SHALL cover overflow: push 9 codes 5'h00..5'h08 -> cell[7] = 5'h01, cell[0] = 5'h08, char_count = 8.
REQ-035 SHALL cover backspace: from the overflow state, backspace ×9 -> after 8 pulses all cells 5'h1F and char_count = 0; the 9th pulse changes nothing.
REQ-036 SHALL cover clear: pulse cmd_clear -> an = 8'hFF and char_ready = 0 for exactly 8 cycles, then all cells 5'h1F; a char_valid held high during clear is accepted on the first IDLE cycle.
REQ-037 SHALL cover collisions: cmd_backspace + char_valid in the same cycle -> backspace only, char_ready = 0; cmd_clear + cmd_backspace -> clear only.
REQ-038 SHALL cover scan and reset: SCAN_DIV=4 -> an steps FE, FD, FB … 7F, FE every 4 cycles; assert rst_n low mid-clear -> an = 8'hFE and char_count = 0 asynchronously.
